pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Parametrised successor of the single-register PC: fetch-stage PC with stall hold,
//  prioritised redirect (trap > jump > branch), deferred redirect while stalled,
//  address masking, alignment check and a PC history line for downstream stages.
//  Sits in IF; drives instruction-memory address, feeds ID/EX/MEM their PCs.
// PARAMETERS
//  N            32           PC width in bits
//  ADDR_MASK    32'h0000FFFF AND-mask applied to every PC written (memory window)
//  RESET_VECTOR 0            PC after reset (masked, low bits aligned)
//  STEP         4            sequential increment; power of two; also alignment unit
//  HIST_DEPTH   3            PC history entries (IF/ID, ID/EX, EX/MEM), >=1
// PORTS
//  clk           in  1             rising-edge clock
//  reset         in  1             asynchronous, active-low reset
//  stall         in  1             1 = hold PC (hazard unit)
//  branch_taken  in  1             branch redirect request
//  branch_target in  N             branch target
//  jump          in  1             jump redirect request
//  jump_target   in  N             jump target
//  trap          in  1             exception redirect request
//  trap_vector   in  N             exception handler address
//  PCValue       out N             current fetch PC (registered)
//  PCPlus4       out N             (PCValue+STEP)&ADDR_MASK, combinational
//  fetch_valid   out 1             1 = PCValue is a valid fetch this cycle
//  misaligned    out 1             one-cycle pulse: last loaded target was misaligned
//  redirect_pend out 1             1 = redirect captured during stall, not yet applied
//  pc_hist       out N*HIST_DEPTH  hist[0] in bits [N-1:0]; hist[k] = PC k+1 advances ago
// BEHAVIOUR
//  Reset (reset==0, async): PCValue=RESET_VECTOR&ADDR_MASK, fetch_valid=0, misaligned=0,
//   redirect_pend=0, pc_hist all 0, pending target 0, state=BOOT. Reset mid-operation
//   discards any pending redirect and history.
//  Target select (same cycle): trap -> trap_vector; else jump -> jump_target;
//   else branch_taken -> branch_target; else sequential PCPlus4.
//  Load rule: PC_next = sel & ADDR_MASK & ~(STEP-1). misaligned<=1 for one cycle when a
//   redirect target with (target & (STEP-1))!=0 is loaded into PCValue, else 0.
//  Wrap: sequential past ADDR_MASK wraps to 0 via mask (0xFFFC -> 0x0000 at defaults).
//  FSM (one state reg):
//   BOOT: PC holds, fetch_valid=0; next edge -> RUN regardless of inputs.
//   RUN : fetch_valid=1. stall=0: PCValue<=PC_next, history shifts.
//         stall=1 & any redirect: capture selected target into pending, -> PEND, PC holds.
//         stall=1 & no redirect: PC holds, history holds.
//   PEND: redirect_pend=1, fetch_valid=1, PC holds. stall=1: trap overwrites pending with
//         trap_vector; jump/branch ignored. stall=0: load trap_vector if trap, else the
//         pending target (masked/aligned, misaligned check applies), history shifts, -> RUN.
//  History: on every PC advance hist[0]<=PCValue, hist[k]<=hist[k-1]; holds when PC holds.
//  Latency: redirect seen at edge t appears on PCValue after edge t (1 cycle) if unstalled.
// TESTING
//  Reset low then high, no stall -> PCValue=0 for BOOT cycle, fetch_valid 0->1, then 4,8,12.
//  Run to PC=0xFFFC, no redirect -> next PCValue=0x0000, pc_hist[0]=0xFFFC.
//  stall=1 with branch_taken, target 0x0100, for 3 cycles, then stall=0 -> PC held,
//   redirect_pend=1 during stall, PCValue=0x0100 one edge after release, pend clears.
//  trap=1, jump=1, branch=1 same cycle (vec 0x0080, jt 0x0200, bt 0x0300) -> PCValue=0x0080.
//  jump_target=0x12346 -> PCValue=0x2344, misaligned=1 for exactly one cycle.
//  reset asserted during PEND -> PCValue=RESET_VECTOR, redirect_pend=0, pc_hist cleared.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl -- fetch-stage program counter.
//
// Holds the fetch PC, advances it sequentially by STEP, or redirects it to a
// trap / jump / branch target (trap wins over jump, jump over branch).
// A redirect that arrives while the pipeline is stalled is remembered and
// applied once the stall releases. Every PC written is ANDed with ADDR_MASK
// and forced to a STEP boundary. A short history of retired fetch PCs is
// kept for the downstream stages.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   stall          1 = hold the PC (hazard unit)
//   branch_taken   branch redirect request, target on branch_target
//   jump           jump redirect request, target on jump_target
//   trap           exception redirect request, target on trap_vector
//   PCValue        current fetch PC (registered)
//   PCPlus4        (PCValue + STEP) & ADDR_MASK, combinational
//   fetch_valid    1 = PCValue is a valid fetch this cycle
//   misaligned     one-cycle pulse: the last loaded redirect target was misaligned
//   redirect_pend  1 = a redirect was captured during a stall, not yet applied
//   pc_hist        hist[0] in bits [N-1:0]; hist[k] = PC k+1 advances ago
//
// State | meaning
// ------+---------------------------------------------------------------
// BOOT  | first cycle after reset, PC holds, no valid fetch
// RUN   | normal fetch; advances or captures a redirect while stalled
// PEND  | stalled with a captured redirect waiting for the stall to drop

module pc_fetch_ctrl #(
  parameter int            N            = 32,
  parameter logic [N-1:0]  ADDR_MASK    = N'(32'h0000_FFFF),
  parameter logic [N-1:0]  RESET_VECTOR = '0,
  parameter int            STEP         = 4,
  parameter int            HIST_DEPTH   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [N-1:0]            branch_target,
  input  logic                    jump,
  input  logic [N-1:0]            jump_target,
  input  logic                    trap,
  input  logic [N-1:0]            trap_vector,
  output logic [N-1:0]            PCValue,
  output logic [N-1:0]            PCPlus4,
  output logic                    fetch_valid,
  output logic                    misaligned,
  output logic                    redirect_pend,
  output logic [N*HIST_DEPTH-1:0] pc_hist
);

  localparam logic [N-1:0] STEP_V   = N'(STEP);
  localparam logic [N-1:0] ALIGN_LO = STEP_V - N'(1);
  localparam logic [N-1:0] PC_RESET = RESET_VECTOR & ADDR_MASK & ~ALIGN_LO;

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  state_t                  state_q, state_d;
  logic [N-1:0]            pend_q, pend_d;
  logic [N-1:0]            pc_d;
  logic                    mis_d;
  logic [N*HIST_DEPTH-1:0] hist_d, hist_shift;
  logic [N-1:0]            sel_target, load_target;
  logic                    redirect, advance, load_is_redirect;

  assign PCPlus4       = (PCValue + STEP_V) & ADDR_MASK;
  assign fetch_valid   = (state_q != BOOT);
  assign redirect_pend = (state_q == PEND);
  assign redirect      = trap | jump | branch_taken;

  always_comb begin
    if (trap)              sel_target = trap_vector;
    else if (jump)         sel_target = jump_target;
    else if (branch_taken) sel_target = branch_target;
    else                   sel_target = PCPlus4;
  end

  always_comb begin
    hist_shift = '0;
    hist_shift[N-1:0] = PCValue;
    for (int k = 1; k < HIST_DEPTH; k++) begin
      hist_shift[k*N +: N] = pc_hist[(k-1)*N +: N];
    end
  end

  always_comb begin
    state_d          = state_q;
    pend_d           = pend_q;
    pc_d             = PCValue;
    mis_d            = 1'b0;
    hist_d           = pc_hist;
    advance          = 1'b0;
    load_target      = PCPlus4;
    load_is_redirect = 1'b0;

    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!stall) begin
          advance          = 1'b1;
          load_target      = sel_target;
          load_is_redirect = redirect;
        end else if (redirect) begin
          pend_d  = sel_target;
          state_d = PEND;
        end
      end
      PEND: begin
        if (stall) begin
          // Only a trap may replace the captured target while still stalled.
          if (trap) pend_d = trap_vector;
        end else begin
          advance          = 1'b1;
          load_target      = trap ? trap_vector : pend_q;
          load_is_redirect = 1'b1;
          state_d          = RUN;
        end
      end
      default: state_d = BOOT;
    endcase

    if (advance) begin
      pc_d   = load_target & ADDR_MASK & ~ALIGN_LO;
      // Misalignment is judged on the raw target, before alignment drops the low bits.
      mis_d  = load_is_redirect && ((load_target & ALIGN_LO) != '0);
      hist_d = hist_shift;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      PCValue    <= PC_RESET;
      pend_q     <= '0;
      misaligned <= 1'b0;
      pc_hist    <= '0;
    end else begin
      state_q    <= state_d;
      PCValue    <= pc_d;
      pend_q     <= pend_d;
      misaligned <= mis_d;
      pc_hist    <= hist_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  localparam logic [31:0] MASK = 32'h0000_FFFF;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        trap;
  logic [31:0] trap_vector;
  logic [31:0] PCValue;
  logic [31:0] PCPlus4;
  logic        fetch_valid;
  logic        misaligned;
  logic        redirect_pend;
  logic [95:0] pc_hist;

  pc_fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .trap          (trap),
    .trap_vector   (trap_vector),
    .PCValue       (PCValue),
    .PCPlus4       (PCPlus4),
    .fetch_valid   (fetch_valid),
    .misaligned    (misaligned),
    .redirect_pend (redirect_pend),
    .pc_hist       (pc_hist)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        fv;
    logic        mis;
    logic        pend;
    logic [95:0] hist;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: what the fetch PC should be, described by its rules.
  logic [31:0] m_pc;
  logic [31:0] m_pend_tgt;
  logic [31:0] m_hist[$];
  bit          m_booted;
  bit          m_pending;
  bit          m_mis;

  task automatic model_load(input logic [31:0] tgt, input bit is_redirect);
    m_hist.push_front(m_pc);
    void'(m_hist.pop_back());
    m_pc  = tgt & MASK & 32'hFFFF_FFFC;
    m_mis = is_redirect && (tgt % 4 != 0);
  endtask

  task automatic step(input bit rst_b, input bit st,
                      input bit br, input logic [31:0] bt,
                      input bit jp, input logic [31:0] jt,
                      input bit tp, input logic [31:0] tv);
    exp_t e;
    logic [31:0] chosen;
    @(negedge clk);
    reset = rst_b; stall = st;
    branch_taken = br; branch_target = bt;
    jump = jp; jump_target = jt;
    trap = tp; trap_vector = tv;
    chosen = tp ? tv : (jp ? jt : bt);
    if (!rst_b) begin
      m_pc = 32'h0; m_booted = 0; m_pending = 0; m_mis = 0;
      m_pend_tgt = 32'h0;
      m_hist = '{32'h0, 32'h0, 32'h0};
    end else if (!m_booted) begin
      m_booted = 1; m_mis = 0;
    end else if (m_pending) begin
      if (st) begin
        if (tp) m_pend_tgt = tv;
        m_mis = 0;
      end else begin
        model_load(tp ? tv : m_pend_tgt, 1);
        m_pending = 0;
      end
    end else if (st) begin
      if (tp || jp || br) begin
        m_pending  = 1;
        m_pend_tgt = chosen;
      end
      m_mis = 0;
    end else if (tp || jp || br) begin
      model_load(chosen, 1);
    end else begin
      model_load(m_pc + 32'd4, 0);
    end
    e.pc   = m_pc;
    e.fv   = m_booted;
    e.mis  = m_mis;
    e.pend = m_pending;
    e.hist = {m_hist[2], m_hist[1], m_hist[0]};
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock edge, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc",        {64'h0, PCValue},       {64'h0, e.pc});
        chk("pcplus4",   {64'h0, PCPlus4},       {64'h0, (e.pc + 32'd4) & MASK});
        chk("fetch_vld", {95'h0, fetch_valid},   {95'h0, e.fv});
        chk("misalign",  {95'h0, misaligned},    {95'h0, e.mis});
        chk("redir_pnd", {95'h0, redirect_pend}, {95'h0, e.pend});
        chk("pc_hist",   pc_hist,                e.hist);
      end
    end
  end

  task automatic run_seq(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0;
    trap = 1'b0; trap_vector = '0;

    // Reset, BOOT cycle, then 4, 8, 12.
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    run_seq(5);

    // Wrap at the top of the memory window.
    step(1, 0, 0, 0, 1, 32'h0000_FFF0, 0, 0);
    run_seq(5);

    // Branch held off by a 3-cycle stall, applied on release.
    step(1, 1, 1, 32'h0000_0100, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h0000_0300, 1, 32'h0000_0400, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    run_seq(2);

    // Trap beats jump and branch in the same cycle.
    step(1, 0, 1, 32'h0000_0300, 1, 32'h0000_0200, 1, 32'h0000_0080);
    run_seq(1);

    // Misaligned jump target outside the window.
    step(1, 0, 0, 0, 1, 32'h0001_2346, 0, 0);
    run_seq(2);

    // Trap overrides a pending branch while stalled; misaligned trap on release.
    step(1, 1, 1, 32'h0000_0500, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 32'h0000_0702);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    run_seq(1);

    // Reset while a redirect is pending.
    step(1, 1, 1, 32'h0000_0900, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    run_seq(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom(),
           $urandom_range(0, 5) == 0, $urandom(),
           $urandom_range(0, 9) == 0, $urandom());
    end

    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
